stage_sequencer: RTL
====================

# stage_sequencer

Multi-cycle control sequencer for the single-issue MIPS core. It generates the 3-bit `stage` code consumed by fetch, decode, execute, memory and writeback, and owns the 4-bit program counter. It also handles branch redirection, memory-stage skipping, stalls and program termination. It sits at the top of the datapath and is the only driver of `stage` and `pc`.

## Interface
- `INSTR_COUNT`, 12: number of valid instruction words; legal PC range is 0..INSTR_COUNT-1.
- `PC_WIDTH`, 4: PC width in bits.
- `clock` in 1: rising-edge clock for all state.
- `reset` in 1: reset is synchronous and active-high.
- `start` in 1: level sampled in IDLE or HALTED; begins execution at PC 0.
- `stall` in 1: when high in RUN, freezes stage, pc and all internal state.
- `halt` in 1: decoded halt instruction, sampled only when stage==1.
- `skip_mem` in 1: instruction has no memory access, sampled only when stage==2.
- `branch_taken` in 1: sampled only when stage==2.
- `branch_target` in PC_WIDTH: sampled together with `branch_taken`.
- `stage` out 3: 0=IF, 1=ID, 2=EX, 3=MEM, 4=WB, 7=inactive (IDLE/HALTED).
- `pc` out PC_WIDTH: address of the instruction in flight.
- `running` out 1: high in RUN.
- `done` out 1: high in HALTED.
- `error` out 1: high in HALTED when termination was caused by an out-of-range redirect.
- `retire_count` out 8: instructions completed (WB exits), saturating at 255.

## Operation
- Top FSM states: IDLE, RUN, HALTED. Stage codes 5 and 6 are never driven.
- Reset (any state, any stage) forces the following on the next edge:
  - state=IDLE, stage=7, pc=0
  - running=0, done=0, error=0, retire_count=0
  - branch latch cleared
- **IDLE**:
  - `start`=1 → RUN with stage=0, pc=0.
  - Otherwise hold.
- **RUN**, stall=0, per stage:
  - **0 → 1**.
  - **1**:
    - halt=1 → HALTED, error=0. The halt instruction does not retire.
    - Otherwise → 2.
  - **2**:
    - Latch `branch_taken` and `branch_target` into a pending redirect.
    - skip_mem=1 → 4; otherwise → 3.
  - **3 → 4**.
  - **4**: the instruction retires and retire_count increments unless it is at 255. Compute next PC:
    - Pending redirect: next = latched target.
    - No redirect: next = pc+1, computed in PC_WIDTH+1 bits.
  - **Leaving stage 4**:
    - next < INSTR_COUNT → stage=0, pc=next; redirect latch cleared.
    - next ≥ INSTR_COUNT via sequential increment → HALTED, error=0.
    - next ≥ INSTR_COUNT via redirect → HALTED, error=1.
  - In both HALTED cases pc keeps the last executed address.
- **RUN**, stall=1: no register changes. Stall outranks halt, skip_mem and branch sampling; those inputs are re-sampled on the first unstalled cycle.
- **HALTED**:
  - Hold all outputs.
  - `start`=1 → RUN with stage=0, pc=0, done=0, error=0, redirect latch cleared.
  - retire_count is not cleared by restart.
- `stall` is ignored outside RUN.
- `halt`, `skip_mem` and `branch_*` are ignored outside their sampling stage.

## Timing
- All outputs are registered and change only on the rising edge of `clock`.
- stage=0 is held for exactly one unstalled cycle, so fetch captures each instruction once.
- Start latency: `start` high at edge N → stage=0 and running=1 after edge N+1.
- Instruction latency without stalls:
  - 5 cycles with MEM.
  - 4 cycles with skip_mem=1.
  - 2 cycles for halt (IF, ID).
- Redirect: the target PC appears together with stage=0 on the edge leaving WB. There is no wrong-path fetch.
- done/running switch on the same edge that leaves ID (halt) or WB (end of program).
- Simultaneous start and reset: reset wins.

## Test plan
- **Reset then idle**: reset=1 for 2 cycles, start=0 for 5 cycles → stage=7, pc=0, running=0, done=0 throughout.
- **Straight-line run**: start pulse, INSTR_COUNT=12, skip_mem=0, no branches.
  - stage sequence 0,1,2,3,4 per instruction; pc steps 0..11.
  - After 60 run cycles: done=1, error=0, pc=11, retire_count=12.
- **Skip and branch**: at pc=3 assert skip_mem=1 and branch_taken=1 with target=8 during stage 2.
  - Stages 0,1,2,4, then stage=0 with pc=8; retire_count +1.
- **Out-of-range redirect**: at pc=5 branch to target=13.
  - After WB: done=1, error=1, pc=5, stage=7.
- **Halt and stall**:
  - halt=1 in ID at pc=2 → HALTED after 2 cycles, retire_count=2.
  - stall=1 for 3 cycles during stage 3 → stage and pc frozen for 3 cycles, then resume at stage 4.
- **Reset mid-operation, then restart**:
  - reset at stage 2, pc=6 → next cycle IDLE, retire_count=0.
  - start from HALTED → pc=0, done=0, retire_count retained.

Source files
------------

// File: rtl/stage_sequencer.sv
// Multi-cycle stage/PC sequencer for the single-issue core: walks IF..WB,
// handles branch redirects, memory-stage skipping, stalls and termination.
//
// state  | meaning
// IDLE   | out of reset, waiting for start; stage=7
// RUN    | stepping stages 0..4 for the instruction at pc
// HALTED | program terminated (halt or PC past end); stage=7, pc holds last address
module stage_sequencer #(
    parameter int INSTR_COUNT = 12,
    parameter int PC_WIDTH    = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic                stall,
    input  logic                halt,
    input  logic                skip_mem,
    input  logic                branch_taken,
    input  logic [PC_WIDTH-1:0] branch_target,
    output logic [2:0]          stage,
    output logic [PC_WIDTH-1:0] pc,
    output logic                running,
    output logic                done,
    output logic                error,
    output logic [7:0]          retire_count
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_t;

    localparam logic [2:0] ST_IF       = 3'd0;
    localparam logic [2:0] ST_ID       = 3'd1;
    localparam logic [2:0] ST_EX       = 3'd2;
    localparam logic [2:0] ST_MEM      = 3'd3;
    localparam logic [2:0] ST_WB       = 3'd4;
    localparam logic [2:0] ST_INACTIVE = 3'd7;

    localparam logic [PC_WIDTH:0] PC_LIMIT = INSTR_COUNT[PC_WIDTH:0];
    localparam logic [PC_WIDTH:0] PC_ONE   = {{PC_WIDTH{1'b0}}, 1'b1};

    state_t              state_q, state_d;
    logic [2:0]          stage_q, stage_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic                error_q, error_d;
    logic [7:0]          retire_q, retire_d;
    logic                br_pend_q, br_pend_d;
    logic [PC_WIDTH-1:0] br_tgt_q, br_tgt_d;
    logic [PC_WIDTH:0]   pc_next;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            stage_q   <= ST_INACTIVE;
            pc_q      <= '0;
            error_q   <= 1'b0;
            retire_q  <= 8'd0;
            br_pend_q <= 1'b0;
            br_tgt_q  <= '0;
        end else begin
            state_q   <= state_d;
            stage_q   <= stage_d;
            pc_q      <= pc_d;
            error_q   <= error_d;
            retire_q  <= retire_d;
            br_pend_q <= br_pend_d;
            br_tgt_q  <= br_tgt_d;
        end
    end

    // One extra bit so the increment past the top of the PC range is visible.
    assign pc_next = br_pend_q ? {1'b0, br_tgt_q} : ({1'b0, pc_q} + PC_ONE);

    always_comb begin
        state_d   = state_q;
        stage_d   = stage_q;
        pc_d      = pc_q;
        error_d   = error_q;
        retire_d  = retire_q;
        br_pend_d = br_pend_q;
        br_tgt_d  = br_tgt_q;

        case (state_q)
            IDLE, HALTED: begin
                if (start) begin
                    state_d   = RUN;
                    stage_d   = ST_IF;
                    pc_d      = '0;
                    error_d   = 1'b0;
                    br_pend_d = 1'b0;
                end
            end
            RUN: begin
                if (!stall) begin
                    case (stage_q)
                        ST_IF: stage_d = ST_ID;
                        ST_ID: begin
                            if (halt) begin
                                state_d = HALTED;
                                stage_d = ST_INACTIVE;
                                error_d = 1'b0;
                            end else begin
                                stage_d = ST_EX;
                            end
                        end
                        ST_EX: begin
                            br_pend_d = branch_taken;
                            br_tgt_d  = branch_target;
                            stage_d   = skip_mem ? ST_WB : ST_MEM;
                        end
                        ST_MEM: stage_d = ST_WB;
                        ST_WB: begin
                            if (retire_q != 8'd255) begin
                                retire_d = retire_q + 8'd1;
                            end
                            if (pc_next < PC_LIMIT) begin
                                stage_d   = ST_IF;
                                pc_d      = pc_next[PC_WIDTH-1:0];
                                br_pend_d = 1'b0;
                            end else begin
                                state_d = HALTED;
                                stage_d = ST_INACTIVE;
                                error_d = br_pend_q;
                            end
                        end
                        default: begin
                            state_d = IDLE;
                            stage_d = ST_INACTIVE;
                        end
                    endcase
                end
            end
            default: begin
                state_d = IDLE;
                stage_d = ST_INACTIVE;
            end
        endcase
    end

    assign stage        = stage_q;
    assign pc           = pc_q;
    assign running      = (state_q == RUN);
    assign done         = (state_q == HALTED);
    assign error        = error_q;
    assign retire_count = retire_q;

endmodule
